// File: rtl/line_fill_responder_pkg.sv
// rtl/line_fill_responder_pkg.sv - nextbus types and line geometry shared by cache and responder
package cachepkg;

  localparam int LINEITEMS_DEFAULT = 16;
  localparam int WORDBITS_DEFAULT  = 32;

  typedef enum logic [1:0] {
    NOP        = 2'd0,
    READ_LINE  = 2'd1,
    WRITE_LINE = 2'd2,
    FLUSH      = 2'd3
  } next_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_WRITE,
    S_FLUSH
  } resp_state_t;

endpackage

// File: rtl/line_fill_responder_if.sv
// rtl/line_fill_responder_if.sv - nextbus request, write-beat and read-beat channels
interface line_fill_responder_if #(
  parameter int ADDRBITS = 32,
  parameter int WORDBITS = cachepkg::WORDBITS_DEFAULT
);
  import cachepkg::*;

  logic                req_valid;
  logic                req_ready;
  next_op_t            req_op;
  logic [ADDRBITS-1:0] req_addr;
  logic                wr_valid;
  logic                wr_ready;
  logic [WORDBITS-1:0] wr_data;
  logic                rd_valid;
  logic [WORDBITS-1:0] rd_data;
  logic                rd_last;

  modport master (
    output req_valid, req_op, req_addr, wr_valid, wr_data,
    input  req_ready, wr_ready, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  req_valid, req_op, req_addr, wr_valid, wr_data,
    output req_ready, wr_ready, rd_valid, rd_data, rd_last
  );

endinterface

// File: rtl/line_fill_responder_line_store.sv
// rtl/line_fill_responder_line_store.sv - backing array, one write port, one registered read port
module line_store #(
  parameter int WORDBITS = 32,
  parameter int ADDRW    = 14
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic [ADDRW-1:0]    waddr_i,
  input  logic [WORDBITS-1:0] wdata_i,
  input  logic                re_i,
  input  logic [ADDRW-1:0]    raddr_i,
  output logic [WORDBITS-1:0] rdata_o
);

  // Array contents deliberately survive reset so a line written before an abort stays visible.
  logic [WORDBITS-1:0] mem_q [2**ADDRW];
  logic [WORDBITS-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_fill_responder.sv
// rtl/line_fill_responder.sv - nextbus responder: fixed-latency line reads, beat-wise line writebacks
module line_fill_responder
  import cachepkg::*;
#(
  parameter int ADDRBITS  = 32,
  parameter int WORDBITS  = WORDBITS_DEFAULT,
  parameter int LINEITEMS = LINEITEMS_DEFAULT,
  parameter int MEMLINES  = 1024,
  parameter int LATENCY   = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  line_fill_responder_if.slave bus,
  output logic                 busy,
  output logic [31:0]          read_count,
  output logic [31:0]          write_count
);

  localparam int BEATW  = $clog2(LINEITEMS);
  localparam int IDXW   = $clog2(MEMLINES);
  localparam int OFFSET = BEATW + $clog2(WORDBITS / 8);
  localparam int LATW   = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(LINEITEMS - 1);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  resp_state_t         state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [BEATW-1:0]    beat_q, beat_d;
  logic [LATW-1:0]     lat_q, lat_d;
  logic [31:0]         read_count_q, read_count_d;
  logic [31:0]         write_count_q, write_count_d;
  logic                accept;
  logic                store_we;
  logic [IDXW-1:0]     req_idx;
  logic [WORDBITS-1:0] rd_data_w;
  logic                unused_addr_bits;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n = rst_sync_q[1];

  assign req_idx          = bus.req_addr[OFFSET+IDXW-1:OFFSET];
  assign unused_addr_bits = ^bus.req_addr;
  assign accept           = bus.req_valid && (state_q == S_IDLE) && (bus.req_op != NOP);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    beat_d        = beat_q;
    lat_d         = lat_q;
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    store_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          idx_d = req_idx;
          case (bus.req_op)
            READ_LINE: begin
              state_d = S_WAIT;
              lat_d   = LATW'(LATENCY - 1);
            end
            WRITE_LINE: begin
              state_d = S_WRITE;
              beat_d  = '0;
            end
            default: begin
              state_d = S_FLUSH;
              lat_d   = LATW'(1);
            end
          endcase
        end
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          state_d = S_READ;
          beat_d  = '0;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_READ: begin
        if (beat_q == LAST_BEAT) begin
          state_d      = S_IDLE;
          beat_d       = '0;
          read_count_d = read_count_q + 32'd1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (bus.wr_valid) begin
          store_we = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d       = S_IDLE;
            beat_d        = '0;
            write_count_d = write_count_q + 32'd1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (lat_q == '0) begin
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      beat_q        <= '0;
      lat_q         <= '0;
      read_count_q  <= '0;
      write_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      beat_q        <= beat_d;
      lat_q         <= lat_d;
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
    end
  end

  // The read port is addressed with the next beat so data lands in the same cycle READ shows it.
  line_store #(
    .WORDBITS(WORDBITS),
    .ADDRW   (IDXW + BEATW)
  ) u_store (
    .clock  (clock),
    .rst_n  (rst_n),
    .we_i   (store_we),
    .waddr_i({idx_q, beat_q}),
    .wdata_i(bus.wr_data),
    .re_i   (state_d == S_READ),
    .raddr_i({idx_q, beat_d}),
    .rdata_o(rd_data_w)
  );

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.wr_ready  = (state_q == S_WRITE);
  assign bus.rd_valid  = (state_q == S_READ);
  assign bus.rd_last   = (state_q == S_READ) && (beat_q == LAST_BEAT);
  assign bus.rd_data   = rd_data_w;
  assign busy          = (state_q != S_IDLE);
  assign read_count    = read_count_q;
  assign write_count   = write_count_q;

endmodule

// File: tb/tb_line_fill_responder.sv
// tb/tb_line_fill_responder.sv - directed bench for line_fill_responder
module tb_line_fill_responder;
  import cachepkg::*;

  localparam int ADDRBITS  = 32;
  localparam int WORDBITS  = 32;
  localparam int LINEITEMS = 16;
  localparam int MEMLINES  = 1024;
  localparam int LATENCY   = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        busy;
  logic [31:0] read_count;
  logic [31:0] write_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] line_buf [LINEITEMS];

  line_fill_responder_if #(.ADDRBITS(ADDRBITS), .WORDBITS(WORDBITS)) bus ();

  line_fill_responder #(
    .ADDRBITS (ADDRBITS),
    .WORDBITS (WORDBITS),
    .LINEITEMS(LINEITEMS),
    .MEMLINES (MEMLINES),
    .LATENCY  (LATENCY)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .busy       (busy),
    .read_count (read_count),
    .write_count(write_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_buf(input logic [31:0] base);
    for (int i = 0; i < LINEITEMS; i++) line_buf[i] = base + 32'(i);
  endtask

  task automatic issue_req(input next_op_t op, input logic [31:0] addr, input string tag);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid = 1'b0;
    bus.req_op    = NOP;
  endtask

  task automatic write_line(input logic [31:0] addr, input int gap_beat, input int nbeats, input string tag);
    issue_req(WRITE_LINE, addr, tag);
    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_beat) begin
        bus.wr_valid = 1'b0;
        step();
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = line_buf[b];
      if (b == 0) check({tag, "_wr_ready"}, {31'd0, bus.wr_ready}, 32'd1);
      step();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic read_line(input logic [31:0] addr, input string tag);
    int lat;
    issue_req(READ_LINE, addr, tag);
    lat = 0;
    while (!bus.rd_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LATENCY));
    for (int b = 0; b < LINEITEMS; b++) begin
      check($sformatf("%s_data%0d", tag, b), bus.rd_data, line_buf[b]);
      check($sformatf("%s_last%0d", tag, b), {31'd0, bus.rd_last}, (b == LINEITEMS - 1) ? 32'd1 : 32'd0);
      step();
    end
    check({tag, "_valid_drop"}, {31'd0, bus.rd_valid}, 32'd0);
    check({tag, "_data_hold"}, bus.rd_data, line_buf[LINEITEMS-1]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    int cyc;
    int fcnt;

    bus.req_valid = 1'b0;
    bus.req_op    = NOP;
    bus.req_addr  = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;

    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (3) step();
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("rst_rd_last", {31'd0, bus.rd_last}, 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    check("rst_read_count", read_count, 32'd0);
    check("rst_write_count", write_count, 32'd0);

    fill_buf(32'hA0);
    write_line(32'h0000_0400, -1, LINEITEMS, "wr1");
    check("wr1_write_count", write_count, 32'd1);
    check("wr1_busy", {31'd0, busy}, 32'd0);
    read_line(32'h0000_0400, "rd1");
    check("rd1_read_count", read_count, 32'd1);

    fill_buf(32'h1111_1100);
    write_line(32'h0000_0040, -1, LINEITEMS, "wr_alias");
    read_line(32'h0001_0040, "rd_alias");
    check("alias_read_count", read_count, 32'd2);
    check("alias_write_count", write_count, 32'd2);

    // Request held through a read burst; a FLUSH is queued behind it.
    fill_buf(32'hA0);
    bus.req_valid = 1'b1;
    bus.req_op    = READ_LINE;
    bus.req_addr  = 32'h0000_0400;
    step();
    bus.req_op    = FLUSH;
    bus.req_addr  = '0;
    viol = 0;
    cyc  = 0;
    while (!(bus.rd_valid && bus.rd_last) && cyc < 40) begin
      if (bus.req_ready) viol++;
      step();
      cyc++;
    end
    check("hold_ready_during_burst", 32'(viol), 32'd0);
    check("hold_burst_cycles", 32'(cyc), 32'(LATENCY + LINEITEMS - 1));
    check("hold_ready_at_last", {31'd0, bus.req_ready}, 32'd0);
    step();
    check("hold_ready_after_last", {31'd0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid = 1'b0;
    bus.req_op    = NOP;
    check("flush_busy", {31'd0, busy}, 32'd1);
    check("flush_ready", {31'd0, bus.req_ready}, 32'd0);
    fcnt = 0;
    while (busy && fcnt < 10) begin
      step();
      fcnt++;
    end
    check("flush_busy_cycles", 32'(fcnt), 32'd2);
    check("flush_read_count", read_count, 32'd3);
    check("flush_write_count", write_count, 32'd2);

    bus.req_valid = 1'b1;
    bus.req_op    = NOP;
    repeat (3) step();
    check("nop_busy", {31'd0, busy}, 32'd0);
    check("nop_ready", {31'd0, bus.req_ready}, 32'd1);
    check("nop_read_count", read_count, 32'd3);
    check("nop_write_count", write_count, 32'd2);
    bus.req_valid = 1'b0;

    fill_buf(32'h2200);
    write_line(32'h0000_0080, 1, LINEITEMS, "wr_gap");
    check("gap_write_count", write_count, 32'd3);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hDEAD_BEEF;
    repeat (3) step();
    bus.wr_valid = 1'b0;
    check("idle_wr_busy", {31'd0, busy}, 32'd0);
    check("idle_wr_write_count", write_count, 32'd3);
    read_line(32'h0000_0080, "rd_gap");

    fill_buf(32'h60);
    write_line(32'h0000_00C0, -1, LINEITEMS, "wr_old");
    for (int i = 0; i < 6; i++) line_buf[i] = 32'h50 + 32'(i);
    write_line(32'h0000_00C0, -1, 6, "wr_part");
    check("part_busy_before_rst", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    check("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("mid_rst_rd_data", bus.rd_data, 32'd0);
    check("mid_rst_write_count", write_count, 32'd0);
    check("mid_rst_read_count", read_count, 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    read_line(32'h0000_00C0, "rd_part");
    check("part_read_count", read_count, 32'd1);
    check("part_write_count", write_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
